psum_drain_unit: RTL and testbench

- Parametrised output collector for an N-channel PE array. It replaces the fixed 3-way output mux and saturation logic at the array top level.
- Accepts signed partial sums from NUM_CH PE-column outputs over valid/ready handshakes and arbitrates among them round-robin.
- Converts each accepted sum to OUT_W bits in one of three modes, buffers the results in a shared FIFO, and presents them on a single ready/valid output port with a channel tag.
- Also keeps a clamp/overflow event counter for host readback.

---
 rtl/psum_drain_unit.sv | 173 +++++++++++++++++
 tb/tb_psum_drain_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain_unit.sv
// psum_drain_unit: round-robin collector for NUM_CH signed psum channels.
// Converts each sum to OUT_W bits (sat / sat+ReLU / wrap), queues it in a
// first-word-fall-through FIFO with its channel tag, counts overflows.
// Ports:
//   clk, rst           clock, async active-high reset
//   psum_i             packed psums, channel i at [i*PSUM_W +: PSUM_W]
//   psum_valid_i/_o    per-channel valid / one-hot ready
//   mode_i             00 sat, 01 sat+ReLU, 10 wrap, 11 as 00
//   out_data_o         FIFO head data
//   out_ch_o           head source channel
//   out_ovf_o          head was out of OUT_W range
//   out_valid_o        FIFO non-empty
//   out_ready_i        downstream pops head
//   level_o            FIFO occupancy
//   ovf_count_o        saturating overflow event count
//   ovf_clr_i          synchronous clear of the count
module psum_drain_unit #(
  parameter int NUM_CH     = 3,
  parameter int PSUM_W     = 10,
  parameter int OUT_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH*PSUM_W-1:0]      psum_i,
  input  logic [NUM_CH-1:0]             psum_valid_i,
  output logic [NUM_CH-1:0]             psum_ready_o,
  input  logic [1:0]                    mode_i,
  output logic [OUT_W-1:0]              out_data_o,
  output logic [$clog2(NUM_CH)-1:0]     out_ch_o,
  output logic                          out_ovf_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic [CNT_W-1:0]              ovf_count_o,
  input  logic                          ovf_clr_i
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int HB    = PSUM_W - OUT_W + 1;

  localparam logic [CH_W:0]      NCH  = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0]    LAST = CH_W'(NUM_CH - 1);
  localparam logic [LVL_W-1:0]   FULL = LVL_W'(FIFO_DEPTH);

  logic [CH_W-1:0]  rr_q, rr_d;
  logic [PTR_W-1:0] wp_q, rp_q;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [OUT_W-1:0] mem_data [FIFO_DEPTH];
  logic [CH_W-1:0]  mem_ch   [FIFO_DEPTH];
  logic             mem_ovf  [FIFO_DEPTH];

  logic              full, empty, push, pop;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   gidx;
  logic [CH_W:0]     cand;
  logic [CH_W-1:0]   cidx;
  logic [PSUM_W-1:0] sel;
  logic [HB-1:0]     top;
  logic              ovf;
  logic [OUT_W-1:0]  sat, cval;

  assign full  = (lvl_q == FULL);
  assign empty = (lvl_q == '0);
  assign pop   = !empty && out_ready_i;

  // Search from rr_q upward, wrapping; readiness ignores same-cycle pops.
  always_comb begin
    grant = '0;
    gidx  = '0;
    push  = 1'b0;
    cand  = '0;
    cidx  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, rr_q} + (CH_W+1)'(i);
      if (cand >= NCH) cand = cand - NCH;
      cidx = cand[CH_W-1:0];
      if (!push && psum_valid_i[cidx]) begin
        push = 1'b1;
        gidx = cidx;
      end
    end
    if (full || rst) push = 1'b0;
    if (push) grant[gidx] = 1'b1;
  end

  assign psum_ready_o = grant;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gidx == CH_W'(i)) sel = psum_i[i*PSUM_W +: PSUM_W];
    end
  end

  // In range iff all bits above the OUT_W sign bit match it.
  assign top = sel[PSUM_W-1:OUT_W-1];
  assign ovf = !((&top) || !(|top));

  always_comb begin
    sat = sel[OUT_W-1:0];
    if (ovf) begin
      sat = sel[PSUM_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                          : {1'b0, {(OUT_W-1){1'b1}}};
    end
    case (mode_i)
      2'b10:   cval = sel[OUT_W-1:0];
      2'b01:   cval = sel[PSUM_W-1] ? '0 : sat;
      default: cval = sat;
    endcase
  end

  always_comb begin
    lvl_d = lvl_q;
    case ({push, pop})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
  end

  always_comb begin
    rr_d = rr_q;
    if (push) rr_d = (gidx == LAST) ? '0 : gidx + 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ovf_clr_i) begin
      cnt_d = (push && ovf) ? CNT_W'(1) : '0;
    end else if (push && ovf && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q  <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
      cnt_q <= '0;
    end else begin
      rr_q  <= rr_d;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wp_q] <= cval;
      mem_ch[wp_q]   <= gidx;
      mem_ovf[wp_q]  <= ovf;
    end
  end

  // Head fields are forced to zero when empty so reset shows all zeros.
  assign out_valid_o = !empty;
  assign out_data_o  = empty ? '0 : mem_data[rp_q];
  assign out_ch_o    = empty ? '0 : mem_ch[rp_q];
  assign out_ovf_o   = empty ? 1'b0 : mem_ovf[rp_q];
  assign level_o     = lvl_q;
  assign ovf_count_o = cnt_q;

endmodule

// File: tb/tb_psum_drain_unit.sv
// tb_psum_drain_unit: directed + random stimulus against a queue model
// of psum_drain_unit (arbitration, conversion, FIFO, overflow count).
module tb_psum_drain_unit;

  typedef struct packed {
    logic [1:0] ch;
    logic       ovf;
    logic [7:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] psum;
  logic [2:0]  vld = '0;
  logic [2:0]  rdy;
  logic [1:0]  md = '0;
  logic [7:0]  od;
  logic [1:0]  och;
  logic        oovf, ov;
  logic        ordy = 1'b0;
  logic        clr = 1'b0;
  logic [2:0]  lvl;
  logic [15:0] cnt_o;

  int   pv [3];
  int   errors = 0;
  int   checks = 0;
  ent_t q [$];
  int   rr = 0;
  int   cnt = 0;

  psum_drain_unit #(
    .NUM_CH(3), .PSUM_W(10), .OUT_W(8), .FIFO_DEPTH(4), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .psum_i(psum),
    .psum_valid_i(vld),
    .psum_ready_o(rdy),
    .mode_i(md),
    .out_data_o(od),
    .out_ch_o(och),
    .out_ovf_o(oovf),
    .out_valid_o(ov),
    .out_ready_i(ordy),
    .level_o(lvl),
    .ovf_count_o(cnt_o),
    .ovf_clr_i(clr)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic ent_t conv(int v, logic [1:0] m, int c);
    ent_t e;
    int   d;
    e.ovf = (v < -128) || (v > 127);
    if (m == 2'b10) d = v & 255;
    else if (m == 2'b01 && v < 0) d = 0;
    else if (v > 127) d = 127;
    else if (v < -128) d = -128;
    else d = v;
    e.d  = 8'(d);
    e.ch = 2'(c);
    return e;
  endfunction

  // Checks pre-edge outputs against the model, then advances the model.
  task automatic cycle();
    logic [2:0] er;
    int         g;
    int         v;
    ent_t       e;
    psum = {10'(pv[2]), 10'(pv[1]), 10'(pv[0])};
    #1;
    er = '0;
    g  = -1;
    if (q.size() < 4) begin
      for (int i = 0; i < 3; i++) begin
        if (g < 0 && vld[(rr + i) % 3]) g = (rr + i) % 3;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("ready", 32'(rdy), 32'(er));
    chk("valid", 32'(ov), 32'(q.size() > 0));
    chk("level", 32'(lvl), 32'(q.size()));
    chk("count", 32'(cnt_o), 32'(cnt));
    if (q.size() > 0) begin
      chk("data", 32'(od), 32'(q[0].d));
      chk("ch", 32'(och), 32'(q[0].ch));
      chk("ovf", 32'(oovf), 32'(q[0].ovf));
    end
    e = '0;
    if (g >= 0) begin
      v = int'($signed(10'(pv[g])));
      e = conv(v, md, g);
    end
    @(posedge clk);
    if (ordy && q.size() > 0) void'(q.pop_front());
    if (g >= 0) begin
      q.push_back(e);
      rr = (g + 1) % 3;
    end
    if (clr) cnt = (g >= 0 && e.ovf) ? 1 : 0;
    else if (g >= 0 && e.ovf && cnt < 65535) cnt++;
    #1;
  endtask

  initial begin
    pv[0] = 0; pv[1] = 0; pv[2] = 0;
    psum = '0;
    #2;
    chk("rst_valid", 32'(ov), 0);
    chk("rst_level", 32'(lvl), 0);
    chk("rst_count", 32'(cnt_o), 0);
    chk("rst_data", 32'(od), 0);
    chk("rst_ready", 32'(rdy), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single in-range psum on channel 1
    ordy = 1'b0; md = 2'b00;
    vld = 3'b010; pv[1] = 100;
    cycle();
    vld = '0;
    #1;
    chk("t1_data", 32'(od), 32'h64);
    chk("t1_ch", 32'(och), 1);
    chk("t1_ovf", 32'(oovf), 0);
    chk("t1_level", 32'(lvl), 1);
    ordy = 1'b1;
    cycle();

    // Mode 00 saturation, then ReLU and wrap
    ordy = 1'b0; vld = 3'b001;
    pv[0] = 300;  cycle();
    pv[0] = -64;  cycle();
    pv[0] = -300; cycle();
    vld = '0;
    #1;
    chk("t2_count", 32'(cnt_o), 2);
    chk("t2_head", 32'(od), 32'h7F);
    ordy = 1'b1;
    repeat (3) cycle();
    ordy = 1'b0; vld = 3'b001;
    md = 2'b01; pv[0] = -64; cycle();
    md = 2'b10; pv[0] = 300; cycle();
    vld = '0; md = 2'b00;
    #1;
    chk("t2_relu", 32'(od), 32'h00);
    ordy = 1'b1;
    cycle();
    #1;
    chk("t2_wrap", 32'(od), 32'h2C);
    chk("t2_wrap_ovf", 32'(oovf), 1);
    cycle();

    // All channels valid, draining every cycle
    vld = 3'b111; pv[0] = 5; pv[1] = -7; pv[2] = 9;
    repeat (8) cycle();
    vld = '0;
    repeat (2) cycle();

    // Full FIFO back-pressure
    ordy = 1'b0; vld = 3'b001;
    for (int k = 0; k < 5; k++) begin
      pv[0] = 10 + k;
      cycle();
    end
    #1;
    chk("t4_level", 32'(lvl), 4);
    chk("t4_ready", 32'(rdy), 0);
    ordy = 1'b1;
    repeat (3) cycle();
    vld = '0;
    repeat (5) cycle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      vld  = 3'($urandom);
      md   = 2'($urandom);
      ordy = ($urandom_range(3) != 0);
      clr  = ($urandom_range(15) == 0);
      for (int i = 0; i < 3; i++) pv[i] = int'($urandom_range(1023)) - 512;
      cycle();
    end
    clr = 1'b0; vld = '0; ordy = 1'b1; md = 2'b00;
    repeat (5) cycle();

    // Counter saturation and clear priority
    vld = 3'b001; pv[0] = 300;
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    for (int n = 0; n < 70000 && cnt < 65535; n++) cycle();
    #1;
    chk("t5_full", 32'(cnt_o), 32'hFFFF);
    cycle();
    #1;
    chk("t5_sat", 32'(cnt_o), 32'hFFFF);
    clr = 1'b1;
    cycle();
    clr = 1'b0; vld = '0;
    #1;
    chk("t5_clr", 32'(cnt_o), 1);
    repeat (3) cycle();

    // Asynchronous reset with three entries buffered
    ordy = 1'b0; vld = 3'b100; pv[2] = 200;
    repeat (3) cycle();
    vld = '0;
    #1;
    chk("t6_pre", 32'(lvl), 3);
    #1 rst = 1'b1;
    #1;
    chk("t6_valid", 32'(ov), 0);
    chk("t6_level", 32'(lvl), 0);
    chk("t6_count", 32'(cnt_o), 0);
    chk("t6_ready", 32'(rdy), 0);
    q.delete();
    rr = 0; cnt = 0;
    @(posedge clk);
    #2 rst = 1'b0;
    vld = 3'b110; pv[1] = 1; pv[2] = 2;
    #1;
    chk("t6_grant", 32'(rdy), 32'b010);
    cycle();
    vld = '0; ordy = 1'b1;
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
